// File: rtl/comparador_pkg.sv
// Shared types and the compare rule for the 1-bit registered magnitude comparator.
package comparador_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned RES_W         = 3;

    // One-hot result, bit order {maior, menor, igual}
    typedef enum logic [RES_W-1:0] {
        MAIOR = 3'b100,
        MENOR = 3'b010,
        IGUAL = 3'b001
    } cmp_result_e;

    localparam int unsigned BIT_MAIOR = 2;
    localparam int unsigned BIT_MENOR = 1;
    localparam int unsigned BIT_IGUAL = 0;

    function automatic cmp_result_e compare(input logic a, input logic b);
        cmp_result_e res;
        unique case ({a, b})
            2'b10:   res = MAIOR;
            2'b01:   res = MENOR;
            default: res = IGUAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/comparador_1bit_behav_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/comparador_1bit_behav.sv
// Registered 1-bit magnitude comparator with valid qualifier.
// Define COMP_STATS_EN to build the per-result saturating event counters.
module comparador_1bit_behav
    import comparador_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic             maior,
    output logic             menor,
    output logic             igual,
    output logic [CNT_W-1:0] cnt_maior,
    output logic [CNT_W-1:0] cnt_menor,
    output logic [CNT_W-1:0] cnt_igual
);

    cmp_result_e        res_c;
    logic [RES_W-1:0]   flags_q;
    logic [RES_W-1:0]   flags_d;
    logic               valid_q;
    logic               valid_d;

    assign res_c = compare(a, b);

    // Flags hold their last value across idle cycles; out_valid marks fresh results only
    always_comb begin
        flags_d = flags_q;
        valid_d = 1'b0;
        if (in_valid) begin
            flags_d = res_c;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign maior     = flags_q[BIT_MAIOR];
    assign menor     = flags_q[BIT_MENOR];
    assign igual     = flags_q[BIT_IGUAL];

`ifdef COMP_STATS_EN
    logic [RES_W-1:0] inc_c;

    assign inc_c = in_valid ? RES_W'(res_c) : '0;

    sat_counter #(.W(CNT_W)) u_cnt_maior (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc_c[BIT_MAIOR]),
        .count (cnt_maior)
    );

    sat_counter #(.W(CNT_W)) u_cnt_menor (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc_c[BIT_MENOR]),
        .count (cnt_menor)
    );

    sat_counter #(.W(CNT_W)) u_cnt_igual (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc_c[BIT_IGUAL]),
        .count (cnt_igual)
    );
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign cnt_maior      = '0;
    assign cnt_menor      = '0;
    assign cnt_igual      = '0;
`endif

endmodule

// File: tb/tb_comparador_1bit_behav.sv
// Bench for comparador_1bit_behav: directed steps plus random traffic on two counter widths.
module tb_comparador_1bit_behav;

`ifdef COMP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, a, b, clr_cnt;

    logic       ov8, mai8, men8, igu8;
    logic [7:0] cm8, cn8, ci8;
    logic       ov2, mai2, men2, igu2;
    logic [1:0] cm2, cn2, ci2;

    int total = 0;
    int bad   = 0;

    // Reference model: expected flags and plain integer counts per width
    bit       m_valid;
    bit [2:0] m_flags;
    int       m_cnt8 [3];
    int       m_cnt2 [3];

    always #5 clk = ~clk;

    comparador_1bit_behav #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .clr_cnt(clr_cnt),
        .out_valid(ov8), .maior(mai8), .menor(men8), .igual(igu8),
        .cnt_maior(cm8), .cnt_menor(cn8), .cnt_igual(ci8)
    );

    comparador_1bit_behav #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .clr_cnt(clr_cnt),
        .out_valid(ov2), .maior(mai2), .menor(men2), .igual(igu2),
        .cnt_maior(cm2), .cnt_menor(cn2), .cnt_igual(ci2)
    );

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int n);
        return STATS ? n : 0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_flags = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_cnt8[i] = 0;
            m_cnt2[i] = 0;
        end
    endtask

    // Model of one clock edge from the rules: 0=maior, 1=menor, 2=igual
    task automatic model_edge(input bit v, input bit aa, input bit bb, input bit c);
        int idx;
        idx = (aa > bb) ? 0 : ((aa < bb) ? 1 : 2);
        m_valid = v;
        if (v) m_flags = {aa > bb, aa < bb, aa == bb};
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                m_cnt8[i] = 0;
                m_cnt2[i] = 0;
            end else if (v && i == idx) begin
                m_cnt8[i] = (m_cnt8[i] + 1 > 255) ? 255 : m_cnt8[i] + 1;
                m_cnt2[i] = (m_cnt2[i] + 1 > 3) ? 3 : m_cnt2[i] + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, " out_valid w8"}, 32'(ov8), 32'(m_valid));
        cmp({tag, " flags w8"},     32'({mai8, men8, igu8}), 32'(m_flags));
        cmp({tag, " cnt_maior w8"}, 32'(cm8), 32'(exp_cnt(m_cnt8[0])));
        cmp({tag, " cnt_menor w8"}, 32'(cn8), 32'(exp_cnt(m_cnt8[1])));
        cmp({tag, " cnt_igual w8"}, 32'(ci8), 32'(exp_cnt(m_cnt8[2])));
        cmp({tag, " out_valid w2"}, 32'(ov2), 32'(m_valid));
        cmp({tag, " flags w2"},     32'({mai2, men2, igu2}), 32'(m_flags));
        cmp({tag, " cnt_maior w2"}, 32'(cm2), 32'(exp_cnt(m_cnt2[0])));
        cmp({tag, " cnt_menor w2"}, 32'(cn2), 32'(exp_cnt(m_cnt2[1])));
        cmp({tag, " cnt_igual w2"}, 32'(ci2), 32'(exp_cnt(m_cnt2[2])));
    endtask

    task automatic step(input string tag, input bit v, input bit aa, input bit bb, input bit c);
        in_valid = v;
        a        = aa;
        b        = bb;
        clr_cnt  = c;
        @(posedge clk);
        model_edge(v, aa, bb, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        step("idle", 1'b0, 1'b1, 1'b1, 1'b0);

        // Truth table on consecutive cycles
        step("tt00", 1'b1, 1'b0, 1'b0, 1'b0);
        cmp("tt00 flags literal", 32'({mai8, men8, igu8}), 32'(3'b001));
        step("tt01", 1'b1, 1'b0, 1'b1, 1'b0);
        cmp("tt01 flags literal", 32'({mai8, men8, igu8}), 32'(3'b010));
        step("tt10", 1'b1, 1'b1, 1'b0, 1'b0);
        cmp("tt10 flags literal", 32'({mai8, men8, igu8}), 32'(3'b100));
        step("tt11", 1'b1, 1'b1, 1'b1, 1'b0);
        cmp("tt11 flags literal", 32'({mai8, men8, igu8}), 32'(3'b001));

        // Hold with toggling operands while idle
        step("hold_load", 1'b1, 1'b1, 1'b0, 1'b0);
        step("hold1", 1'b0, 1'b0, 1'b1, 1'b0);
        step("hold2", 1'b0, 1'b1, 1'b1, 1'b0);
        step("hold3", 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("hold maior", 32'(mai8), 32'd1);

        // Counting from a clean start, then clear colliding with a valid sample
        step("pre_clr", 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) step("cnt_maior", 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step("cnt_menor", 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) step("cnt_igual", 1'b1, 1'b1, 1'b1, 1'b0);
        cmp("count5 literal", 32'(cm8), 32'(exp_cnt(5)));
        step("clr_with_valid", 1'b1, 1'b0, 1'b0, 1'b1);
        cmp("clr flags literal", 32'({mai8, men8, igu8}), 32'(3'b001));

        // Saturation on the 2-bit instance
        repeat (6) step("sat", 1'b1, 1'b0, 1'b0, 1'b0);
        cmp("sat literal w2", 32'(ci2), 32'(exp_cnt(3)));
        step("sat_hold", 1'b1, 1'b1, 1'b1, 1'b0);

        // Async reset between edges
        step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("in_rst");
        #2;
        rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);
        cmp("post_rst menor", 32'(men8), 32'd1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparador_1bit_behav.md
Name: comparador_1bit_behav

Overview:
- Registered 1-bit magnitude comparator: compares inputs a and b and drives one-hot result flags maior (a>b), menor (a<b) and igual (a==b).
- One cycle of latency, with a valid qualifier on input and output.
- Optional saturating per-result event counters for debug/statistics.
- Leaf block for use as a building element of wider comparators or as a status-flag generator.

Parameters:
- CNT_W, 8, width of each event counter (range 1..32); only meaningful when COMP_STATS_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a/b are sampled when high
- a  input  1  operand A
- b  input  1  operand B
- clr_cnt  input  1  synchronous clear of all counters
- out_valid  output  1  result flags were updated from a valid sample on the previous edge
- maior  output  1  registered a>b
- menor  output  1  registered a<b
- igual  output  1  registered a==b
- cnt_maior  output  CNT_W  count of valid samples with a>b
- cnt_menor  output  CNT_W  count of valid samples with a<b
- cnt_igual  output  CNT_W  count of valid samples with a==b

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, maior, menor, igual = 0 and all counters = 0. This is the only state in which no flag is set.
- Compare function, applied to operands sampled on a clock edge with in_valid=1:
  - a=0,b=0 gives igual=1
  - a=0,b=1 gives menor=1
  - a=1,b=0 gives maior=1
  - a=1,b=1 gives igual=1
  - The other two flags are 0. After the first valid sample, exactly one flag is set at all times.
- Latency: flags and out_valid update on the clock edge that samples in_valid=1, i.e. they are visible one cycle after the input.
- in_valid=0 at an edge: out_valid goes 0; maior/menor/igual hold their last values; counters unchanged.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.
- Counters (COMP_STATS_EN only):
  - On each valid sample, the counter matching the computed result increments by 1.
  - Counters saturate at 2^CNT_W-1; they do not wrap.
  - clr_cnt=1 zeroes all counters on the edge. If a valid sample arrives in the same cycle, clear wins and the increment is dropped.
  - clr_cnt does not affect flags or out_valid.
- Deassertion of rst_n mid-stream: the first valid sample after release behaves as a normal sample.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro COMP_STATS_EN.
- Defined: the three saturating counters and clr_cnt handling are implemented as described above.
- Undefined: counter registers are not built; cnt_* outputs are tied to 0 and clr_cnt is ignored. Flags and out_valid behave identically in both builds.

Decomposition:
- Package comparador_pkg holds:
  - CNT_W_DEFAULT=8
  - a result type with encoding MAIOR=3'b100, MENOR=3'b010, IGUAL=3'b001, ordered as the {maior,menor,igual} bit order
  - a compare function mapping (a,b) to that result
- One sub-module, sat_counter: parameter W; ports clk, rst_n, clr, inc, count. It is instantiated three times inside the COMP_STATS_EN region.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then in_valid=0 -> out_valid=0, maior=menor=igual=0, cnt_*=0.
- Truth table: valid samples (0,0),(0,1),(1,0),(1,1) on consecutive cycles -> one cycle later {maior,menor,igual} = 001, 010, 100, 001; out_valid=1 on each of those cycles.
- Hold: valid (1,0), then in_valid=0 for 3 cycles with a/b toggling -> maior stays 1, out_valid=0, counters frozen.
- Counting (COMP_STATS_EN, CNT_W=8): 5×(1,0), 3×(0,1), 2×(1,1) valid -> cnt_maior=5, cnt_menor=3, cnt_igual=2; then clr_cnt=1 together with valid (0,0) -> all counters 0 and flags 001.
- Saturation (CNT_W=2): 6 valid (0,0) samples -> cnt_igual=3 and stays 3; cnt_maior=cnt_menor=0.
- Async reset mid-stream: assert rst_n low between clock edges after (1,0) was registered -> flags, out_valid and counters go 0 immediately without a clock edge; the next valid (0,1) after release -> menor=1.
